inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 93 +++++++++
 tb/tb_inst_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with a single-entry decode buffer
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        id_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic        misalign,
  output logic [15:0] retired_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        fetch_done;
  logic        handshake;

  // A returning word is only captured when no redirect is competing with it.
  assign fetch_done = (state == REQ) && imem_ack && !flush;
  // The decode handshake completes even when a flush drops the instruction.
  assign handshake  = (state == FULL) && id_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = FULL;
      FULL:    if (id_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = REQ;
  end

  // Memory-side outputs; rst gates the request so it drops without waiting on the flop.
  always_comb begin
    imem_req  = (state == REQ) && !rst;
    imem_addr = pc;
  end

  // PC, decode buffer, misalign pulse and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= 32'h0;
      id_pc       <= 32'h0;
      retired_cnt <= 16'h0;
      misalign    <= 1'b0;
    end else begin
      misalign <= flush & (|flush_pc[1:0]);
      if (handshake) retired_cnt <= retired_cnt + 16'd1;
      if (flush) begin
        pc       <= {flush_pc[31:2], 2'b00};
        id_valid <= 1'b0;
      end else if (fetch_done) begin
        id_instr <= imem_rdata;
        id_pc    <= pc;
        id_valid <= 1'b1;
        pc       <= pc + 32'd4;
      end else if (handshake) begin
        id_valid <= 1'b0;
      end
    end
  end

  assign id_opcode = id_instr[31:26];
  assign id_funct  = id_instr[5:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;

  logic        imem_req, id_valid, misalign;
  logic [31:0] imem_addr, id_instr, id_pc;
  logic [5:0]  id_opcode, id_funct;
  logic [15:0] retired_cnt;

  logic        imem_req_b, id_valid_b, misalign_b;
  logic [31:0] imem_addr_b, id_instr_b, id_pc_b;
  logic [5:0]  id_opcode_b, id_funct_b;
  logic [15:0] retired_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .id_ready(id_ready),
    .flush(flush), .flush_pc(flush_pc), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_opcode(id_opcode), .id_funct(id_funct),
    .misalign(misalign), .retired_cnt(retired_cnt)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .imem_req(imem_req_b), .imem_addr(imem_addr_b),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .id_ready(id_ready),
    .flush(flush), .flush_pc(flush_pc), .id_valid(id_valid_b), .id_instr(id_instr_b),
    .id_pc(id_pc_b), .id_opcode(id_opcode_b), .id_funct(id_funct_b),
    .misalign(misalign_b), .retired_cnt(retired_cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        flush;
    logic [31:0] fpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  localparam logic [31:0] A0 = 32'h1111_0001;
  localparam logic [31:0] A1 = 32'h2222_0002;
  localparam logic [31:0] A2 = 32'h3333_0003;
  localparam logic [31:0] B0 = 32'hB0B0_B0B0;
  localparam logic [31:0] C0 = 32'hC0C0_C0C0;
  localparam logic [31:0] JK = 32'hDEAD_BEEF;

  vec_t tbl[21];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  slot_t       m_held[$];
  bit          m_started;
  logic [31:0] m_next;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [15:0] m_cnt;
  bit          m_mis;

  // Behavioural reference: a pending-fetch address and a buffer of at most one instruction.
  task automatic model_reset();
    m_held.delete();
    m_started = 0;
    m_next    = 32'h0;
    m_instr   = 32'h0;
    m_idpc    = 32'h0;
    m_cnt     = 16'h0;
    m_mis     = 0;
  endtask

  task automatic model_step();
    bit requesting;
    bit holding;
    slot_t s;
    requesting = m_started && (m_held.size() == 0);
    holding    = (m_held.size() != 0);
    if (holding && id_ready) m_cnt = m_cnt + 16'd1;
    m_mis = flush && ((flush_pc % 4) != 0);
    if (flush) begin
      m_held.delete();
      m_next    = flush_pc - (flush_pc % 4);
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (requesting && imem_ack) begin
      s.instr = imem_rdata;
      s.pc    = m_next;
      m_held.push_back(s);
      m_instr = imem_rdata;
      m_idpc  = m_next;
      m_next  = m_next + 32'd4;
    end else if (holding && id_ready) begin
      m_held.delete();
    end
  endtask

  task automatic model_compare();
    bit exp_req;
    exp_req = m_started && (m_held.size() == 0);
    chk("rnd_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("rnd_addr", imem_addr, m_next);
    chk("rnd_valid", 32'(id_valid), 32'(m_held.size() != 0));
    chk("rnd_instr", id_instr, m_instr);
    chk("rnd_pc", id_pc, m_idpc);
    chk("rnd_opcode", 32'(id_opcode), 32'(m_instr / 32'h0400_0000));
    chk("rnd_funct", 32'(id_funct), 32'(m_instr % 64));
    chk("rnd_misalign", 32'(misalign), 32'(m_mis));
    chk("rnd_cnt", 32'(retired_cnt), 32'(m_cnt));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'h0);
    chk({tag, "_req_b"}, 32'(imem_req_b), 32'h0);
    chk({tag, "_valid"}, 32'(id_valid), 32'h0);
    chk({tag, "_instr"}, id_instr, 32'h0);
    chk({tag, "_pc"}, id_pc, 32'h0);
    chk({tag, "_mis"}, 32'(misalign), 32'h0);
    chk({tag, "_cnt"}, 32'(retired_cnt), 32'h0);
  endtask

  initial begin
    // flush, fpc, ack, rdata, ready | req, addr, valid, instr, ipc, mis, cnt
    tbl[0]  = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0, 32'h0,   1'b0, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, A0,    1'b1, 1'b0, 32'h0,   1'b1, A0,    32'h0,   1'b0, 16'd0};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   1'b0, A0,    32'h0,   1'b0, 16'd1};
    tbl[3]  = '{1'b0, 32'h0,   1'b1, A1,    1'b1, 1'b0, 32'h0,   1'b1, A1,    32'h4,   1'b0, 16'd1};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h8,   1'b0, A1,    32'h4,   1'b0, 16'd2};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, A2,    1'b1, 1'b0, 32'h0,   1'b1, A2,    32'h8,   1'b0, 16'd2};
    tbl[6]  = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'hC,   1'b0, A2,    32'h8,   1'b0, 16'd3};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, JK,    1'b1, 1'b1, 32'hC,   1'b0, A2,    32'h8,   1'b0, 16'd3};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, JK,    1'b1, 1'b1, 32'hC,   1'b0, A2,    32'h8,   1'b0, 16'd3};
    tbl[9]  = '{1'b0, 32'h0,   1'b0, JK,    1'b1, 1'b1, 32'hC,   1'b0, A2,    32'h8,   1'b0, 16'd3};
    tbl[10] = '{1'b0, 32'h0,   1'b1, B0,    1'b0, 1'b0, 32'h0,   1'b1, B0,    32'hC,   1'b0, 16'd3};
    for (int i = 11; i <= 15; i++)
      tbl[i] = '{1'b0, 32'h0,  1'b1, JK,    1'b0, 1'b0, 32'h0,   1'b1, B0,    32'hC,   1'b0, 16'd3};
    tbl[16] = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 32'h10,  1'b0, B0,    32'hC,   1'b0, 16'd4};
    tbl[17] = '{1'b1, 32'h103, 1'b1, JK,    1'b0, 1'b1, 32'h100, 1'b0, B0,    32'hC,   1'b1, 16'd4};
    tbl[18] = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, B0,    32'hC,   1'b0, 16'd4};
    tbl[19] = '{1'b0, 32'h0,   1'b1, C0,    1'b0, 1'b0, 32'h0,   1'b1, C0,    32'h100, 1'b0, 16'd4};
    tbl[20] = '{1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b0, C0,    32'h100, 1'b0, 16'd5};

    // Reset held with a stray ack: nothing may leave reset state.
    imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_values("rst_init");
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b0;
    #1 chk("idle_req", 32'(imem_req), 32'h0);
    chk("idle_valid", 32'(id_valid), 32'h0);

    // Directed table: streaming fetch, slow ack, decode stall, flush corners.
    for (int i = 0; i < 21; i++) begin
      flush      = tbl[i].flush;
      flush_pc   = tbl[i].fpc;
      imem_ack   = tbl[i].ack;
      imem_rdata = tbl[i].rdata;
      id_ready   = tbl[i].ready;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      if (tbl[i].req) begin
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
        chk($sformatf("v%0d_addr_b", i), imem_addr_b,
            (i < 17) ? tbl[i].addr - 32'd4 : tbl[i].addr);
      end
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d_instr", i), id_instr, tbl[i].instr);
      chk($sformatf("v%0d_pc", i), id_pc, tbl[i].ipc);
      chk($sformatf("v%0d_opcode", i), 32'(id_opcode), 32'(tbl[i].instr >> 26));
      chk($sformatf("v%0d_funct", i), 32'(id_funct), 32'(tbl[i].instr & 32'h3F));
      chk($sformatf("v%0d_mis", i), 32'(misalign), 32'(tbl[i].mis));
      chk($sformatf("v%0d_cnt", i), 32'(retired_cnt), 32'(tbl[i].cnt));
      @(negedge clk);
    end

    // Reset asserted mid-request: request must drop without waiting for a clock edge.
    flush    = 1'b0;
    imem_ack = 1'b0;
    id_ready = 1'b0;
    chk("pre_rst_req", 32'(imem_req), 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    imem_ack   = 1'b1;
    imem_rdata = JK;
    repeat (2) @(posedge clk);
    #1 check_reset_values("rst_ack");

    // Randomized traffic against the reference model.
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      flush      = ($urandom_range(0, 19) == 0);
      flush_pc   = $urandom();
      imem_ack   = ($urandom_range(0, 1) == 1);
      imem_rdata = $urandom();
      id_ready   = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      model_step();
      #1 model_compare();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
